// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants for the two-master AXI read arbiter: FSM state encoding
// and the AXI burst/response codes used on the read path.
package axi_rd_arbiter_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_IC_AR = 3'd1;
   localparam logic [2:0] ST_IC_R  = 3'd2;
   localparam logic [2:0] ST_LS_AR = 3'd3;
   localparam logic [2:0] ST_LS_R  = 3'd4;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_rd_arbiter.sv
// Merges the icache (burst) and LSU (single-beat) AXI read masters onto one
// system read port. Define ARB_RR_EN for round-robin on simultaneous requests.
module axi_rd_arbiter
   import axi_rd_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              icache_arvalid,
   output logic              icache_arready,
   input  logic [ADDR_W-1:0] icache_araddr,
   input  logic [7:0]        icache_arlen,
   input  logic [2:0]        icache_arsize,
   input  logic [1:0]        icache_arburst,
   output logic              icache_rvalid,
   input  logic              icache_rready,
   output logic [DATA_W-1:0] icache_rdata,
   output logic [1:0]        icache_rresp,
   output logic              icache_rlast,
   input  logic              lsu_arvalid,
   output logic              lsu_arready,
   input  logic [ADDR_W-1:0] lsu_araddr,
   input  logic [2:0]        lsu_arsize,
   output logic              lsu_rvalid,
   input  logic              lsu_rready,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic [1:0]        lsu_rresp,
   output logic              bus_arvalid,
   input  logic              bus_arready,
   output logic [ADDR_W-1:0] bus_araddr,
   output logic [7:0]        bus_arlen,
   output logic [2:0]        bus_arsize,
   output logic [1:0]        bus_arburst,
   input  logic              bus_rvalid,
   output logic              bus_rready,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic [1:0]        bus_rresp,
   input  logic              bus_rlast
);

   logic [2:0] state_q, state_d;
   logic       lsuWins;

`ifdef ARB_RR_EN
   // Remembers which master was granted last; reset value means icache.
   logic lastGrantLsu_q, lastGrantLsu_d;

   assign lsuWins = lsu_arvalid & (~icache_arvalid | ~lastGrantLsu_q);
   assign lastGrantLsu_d = (state_q == ST_IDLE && (lsu_arvalid || icache_arvalid))
                           ? lsuWins : lastGrantLsu_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lastGrantLsu_q <= 1'b0;
      end else begin
         lastGrantLsu_q <= lastGrantLsu_d;
      end
   end
`else
   assign lsuWins = lsu_arvalid;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Every output is zero unless the current state owns it, so reset and
   // IDLE present a quiet bus on both sides.
   always_comb begin
      state_d        = state_q;
      icache_arready = 1'b0;
      lsu_arready    = 1'b0;
      bus_arvalid    = 1'b0;
      bus_araddr     = '0;
      bus_arlen      = '0;
      bus_arsize     = '0;
      bus_arburst    = '0;
      bus_rready     = 1'b0;
      icache_rvalid  = 1'b0;
      icache_rdata   = '0;
      icache_rresp   = '0;
      icache_rlast   = 1'b0;
      lsu_rvalid     = 1'b0;
      lsu_rdata      = '0;
      lsu_rresp      = '0;

      case (state_q)
         ST_IDLE: begin
            if (lsuWins) begin
               state_d = ST_LS_AR;
            end else if (icache_arvalid) begin
               state_d = ST_IC_AR;
            end
         end
         ST_IC_AR: begin
            bus_arvalid    = icache_arvalid;
            bus_araddr     = icache_araddr;
            bus_arlen      = icache_arlen;
            bus_arsize     = icache_arsize;
            bus_arburst    = icache_arburst;
            icache_arready = bus_arready;
            if (icache_arvalid && bus_arready) begin
               state_d = ST_IC_R;
            end
         end
         ST_IC_R: begin
            bus_araddr    = icache_araddr;
            icache_rvalid = bus_rvalid;
            icache_rdata  = bus_rdata;
            icache_rresp  = bus_rresp;
            icache_rlast  = bus_rlast;
            bus_rready    = icache_rready;
            if (bus_rvalid && icache_rready && bus_rlast) begin
               state_d = ST_IDLE;
            end
         end
         ST_LS_AR: begin
            bus_arvalid = lsu_arvalid;
            bus_araddr  = lsu_araddr;
            bus_arsize  = lsu_arsize;
            bus_arburst = AXI_BURST_INCR;
            lsu_arready = bus_arready;
            if (lsu_arvalid && bus_arready) begin
               state_d = ST_LS_R;
            end
         end
         ST_LS_R: begin
            bus_araddr = lsu_araddr;
            lsu_rvalid = bus_rvalid;
            lsu_rdata  = bus_rdata;
            lsu_rresp  = bus_rresp;
            bus_rready = lsu_rready;
            if (bus_rvalid && lsu_rready && bus_rlast) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level arbitration model.
module tb_axi_rd_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              icache_arvalid = 1'b0;
   logic              icache_arready;
   logic [ADDR_W-1:0] icache_araddr = '0;
   logic [7:0]        icache_arlen = '0;
   logic [2:0]        icache_arsize = '0;
   logic [1:0]        icache_arburst = '0;
   logic              icache_rvalid;
   logic              icache_rready = 1'b0;
   logic [DATA_W-1:0] icache_rdata;
   logic [1:0]        icache_rresp;
   logic              icache_rlast;
   logic              lsu_arvalid = 1'b0;
   logic              lsu_arready;
   logic [ADDR_W-1:0] lsu_araddr = '0;
   logic [2:0]        lsu_arsize = '0;
   logic              lsu_rvalid;
   logic              lsu_rready = 1'b0;
   logic [DATA_W-1:0] lsu_rdata;
   logic [1:0]        lsu_rresp;
   logic              bus_arvalid;
   logic              bus_arready = 1'b0;
   logic [ADDR_W-1:0] bus_araddr;
   logic [7:0]        bus_arlen;
   logic [2:0]        bus_arsize;
   logic [1:0]        bus_arburst;
   logic              bus_rvalid = 1'b0;
   logic              bus_rready;
   logic [DATA_W-1:0] bus_rdata = '0;
   logic [1:0]        bus_rresp = '0;
   logic              bus_rlast = 1'b0;

   int checks = 0;
   int errors = 0;

   bit          icPend, lsPend, lastGrantLsu;
   logic [31:0] icAddr, lsAddr;
   logic [7:0]  icLen;
   logic [2:0]  icSize, lsSize;
   logic [1:0]  icBurst;
   int          arDelay, slverrBeat, abortAt;
   bit          rreadyToggle, rvalidGaps, forceDataEn;
   logic [31:0] forceData;

   axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock(clock), .reset(reset),
      .icache_arvalid(icache_arvalid), .icache_arready(icache_arready),
      .icache_araddr(icache_araddr), .icache_arlen(icache_arlen),
      .icache_arsize(icache_arsize), .icache_arburst(icache_arburst),
      .icache_rvalid(icache_rvalid), .icache_rready(icache_rready),
      .icache_rdata(icache_rdata), .icache_rresp(icache_rresp),
      .icache_rlast(icache_rlast),
      .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
      .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize),
      .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
      .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
      .bus_arvalid(bus_arvalid), .bus_arready(bus_arready),
      .bus_araddr(bus_araddr), .bus_arlen(bus_arlen),
      .bus_arsize(bus_arsize), .bus_arburst(bus_arburst),
      .bus_rvalid(bus_rvalid), .bus_rready(bus_rready),
      .bus_rdata(bus_rdata), .bus_rresp(bus_rresp), .bus_rlast(bus_rlast)
   );

   // Free-running 10 ns clock.
   always #5 clock = ~clock;

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference arbitration decision taken purely from who is asking and who
   // was served last.
   function automatic bit expectLsuWins();
      if (lsPend && !icPend) return 1'b1;
      if (icPend && !lsPend) return 1'b0;
`ifdef ARB_RR_EN
      return !lastGrantLsu;
`else
      return 1'b1;
`endif
   endfunction

   // Runs one complete read transaction from IDLE, playing both masters and
   // the system slave, and checks every cycle against the model.
   task automatic applyStimulus();
      bit          winLsu, rr, last;
      logic [31:0] expAddr, d;
      logic [7:0]  expLen;
      logic [2:0]  expSize;
      logic [1:0]  expBurst, rsp;
      int          beats, b, guard, stalls;

      icache_arvalid = icPend;  icache_araddr = icAddr;  icache_arlen = icLen;
      icache_arsize  = icSize;  icache_arburst = icBurst;
      lsu_arvalid    = lsPend;  lsu_araddr = lsAddr;     lsu_arsize = lsSize;
      bus_arready    = 1'b0;
      #1;
      checkOutput("idle_bus_arvalid", bus_arvalid, 0);
      checkOutput("idle_ic_arready", icache_arready, 0);
      checkOutput("idle_lsu_arready", lsu_arready, 0);

      winLsu       = expectLsuWins();
      lastGrantLsu = winLsu;
      expAddr  = winLsu ? lsAddr : icAddr;
      expLen   = winLsu ? 8'd0 : icLen;
      expSize  = winLsu ? lsSize : icSize;
      expBurst = winLsu ? 2'b01 : icBurst;
      beats    = int'(expLen) + 1;
      @(posedge clock); #1;

      for (int k = 0; k <= arDelay; k++) begin
         bus_arready = (k == arDelay);
         #1;
         checkOutput("ar_valid", bus_arvalid, 1);
         checkOutput("ar_addr", bus_araddr, expAddr);
         checkOutput("ar_len", bus_arlen, expLen);
         checkOutput("ar_size", bus_arsize, expSize);
         checkOutput("ar_burst", bus_arburst, expBurst);
         checkOutput("ar_win_ready", winLsu ? lsu_arready : icache_arready, bus_arready);
         checkOutput("ar_lose_ready", winLsu ? icache_arready : lsu_arready, 0);
         @(posedge clock); #1;
      end
      bus_arready = 1'b0;
      if (winLsu) begin
         lsPend = 0; lsu_arvalid = 1'b0;
      end else begin
         icPend = 0; icache_arvalid = 1'b0;
      end

      b = 0; guard = 0; stalls = 0;
      while (b < beats) begin
         guard++;
         if (guard > 200) begin
            checks++; errors++;
            $error("[TB] FAIL beat_timeout observed=%0d expected=%0d", b, beats);
            break;
         end
         if (rvalidGaps && $urandom_range(0, 3) == 0) begin
            bus_rvalid = 1'b0;
            icache_rready = 1'($urandom_range(0, 1));
            lsu_rready    = 1'($urandom_range(0, 1));
            #1;
            checkOutput("gap_rvalid", winLsu ? lsu_rvalid : icache_rvalid, 0);
            @(posedge clock); #1;
            continue;
         end
         d    = forceDataEn ? forceData : $urandom;
         rsp  = (slverrBeat >= 0) ? ((b == slverrBeat) ? 2'b10 : 2'b00)
                                  : 2'($urandom_range(0, 3));
         last = (b == beats - 1);
         rr   = 1'b1;
         if (rreadyToggle && stalls < 2 && $urandom_range(0, 1) == 1) rr = 1'b0;
         stalls = rr ? 0 : stalls + 1;
         bus_rvalid = 1'b1; bus_rdata = d; bus_rresp = rsp; bus_rlast = last;
         if (winLsu) begin
            lsu_rready = rr; icache_rready = 1'($urandom_range(0, 1));
         end else begin
            icache_rready = rr; lsu_rready = 1'($urandom_range(0, 1));
         end
         #1;
         if (abortAt == b) begin
            reset = 1'b0;
            #1;
            checkOutput("rst_ic_rvalid", icache_rvalid, 0);
            checkOutput("rst_ic_rdata", icache_rdata, 0);
            checkOutput("rst_lsu_rvalid", lsu_rvalid, 0);
            checkOutput("rst_bus_rready", bus_rready, 0);
            checkOutput("rst_bus_arvalid", bus_arvalid, 0);
            checkOutput("rst_bus_araddr", bus_araddr, 0);
            @(posedge clock); #1;
            bus_rvalid = 1'b0; bus_rlast = 1'b0;
            icache_arvalid = 1'b0; lsu_arvalid = 1'b0;
            icPend = 0; lsPend = 0; lastGrantLsu = 0;
            reset = 1'b1;
            return;
         end
         checkOutput("r_win_valid", winLsu ? lsu_rvalid : icache_rvalid, 1);
         checkOutput("r_win_data", winLsu ? lsu_rdata : icache_rdata, d);
         checkOutput("r_win_resp", winLsu ? lsu_rresp : icache_rresp, rsp);
         if (!winLsu) checkOutput("r_ic_last", icache_rlast, last);
         checkOutput("r_lose_valid", winLsu ? icache_rvalid : lsu_rvalid, 0);
         checkOutput("r_bus_ready", bus_rready, rr);
         checkOutput("r_lose_arready", winLsu ? icache_arready : lsu_arready, 0);
         @(posedge clock); #1;
         if (rr) b++;
      end
      bus_rvalid = 1'b0; bus_rlast = 1'b0;
   endtask

   task automatic defaults();
      arDelay = 0; slverrBeat = -1; abortAt = -1;
      rreadyToggle = 0; rvalidGaps = 0; forceDataEn = 0;
   endtask

   initial begin
      icPend = 0; lsPend = 0; lastGrantLsu = 0;
      icAddr = '0; lsAddr = '0; icLen = '0; icSize = '0; lsSize = '0; icBurst = '0;
      forceData = '0;
      defaults();

      #2;
      checkOutput("reset_bus_arvalid", bus_arvalid, 0);
      checkOutput("reset_bus_araddr", bus_araddr, 0);
      checkOutput("reset_bus_rready", bus_rready, 0);
      checkOutput("reset_ic_arready", icache_arready, 0);
      checkOutput("reset_lsu_rvalid", lsu_rvalid, 0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;

      $display("[TB] icache burst alone");
      icPend = 1; icAddr = 32'h3000_0000; icLen = 8'd3; icSize = 3'd2; icBurst = 2'b01;
      applyStimulus();

      $display("[TB] LSU load alone");
      lsPend = 1; lsAddr = 32'h8000_0010; lsSize = 3'd2;
      forceDataEn = 1; forceData = 32'hDEAD_BEEF;
      applyStimulus();
      defaults();

      $display("[TB] simultaneous requests");
      icPend = 1; icAddr = 32'h3000_0040; icLen = 8'd3;
      lsPend = 1; lsAddr = 32'h8000_0020;
      applyStimulus();
      applyStimulus();

      $display("[TB] AR backpressure");
      icPend = 1; icAddr = 32'h3000_0080; icLen = 8'd1;
      lsPend = 1; lsAddr = 32'h8000_0030;
      arDelay = 5;
      applyStimulus();
      applyStimulus();
      defaults();

      $display("[TB] SLVERR mid-burst with rready toggling");
      icPend = 1; icAddr = 32'h3000_00C0; icLen = 8'd3; icBurst = 2'b01;
      slverrBeat = 1; rreadyToggle = 1;
      applyStimulus();
      defaults();

      $display("[TB] randomized traffic");
      for (int t = 0; t < 30; t++) begin
         if (!icPend && $urandom_range(0, 1) == 1) begin
            icPend = 1; icAddr = $urandom; icLen = 8'($urandom_range(0, 7));
            icSize = 3'($urandom_range(0, 3)); icBurst = 2'($urandom_range(0, 2));
         end
         if (!lsPend && $urandom_range(0, 1) == 1) begin
            lsPend = 1; lsAddr = $urandom; lsSize = 3'($urandom_range(0, 3));
         end
         if (!icPend && !lsPend) begin
            lsPend = 1; lsAddr = $urandom; lsSize = 3'd2;
         end
         arDelay = $urandom_range(0, 3);
         rreadyToggle = 1'($urandom_range(0, 1));
         rvalidGaps   = 1'($urandom_range(0, 1));
         applyStimulus();
      end
      defaults();
      icPend = 0; lsPend = 0; icache_arvalid = 1'b0; lsu_arvalid = 1'b0;
      @(posedge clock); #1;
      while (icPend || lsPend) applyStimulus();

      $display("[TB] reset mid-burst");
      icPend = 1; icAddr = 32'h3000_0100; icLen = 8'd7; icSize = 3'd2; icBurst = 2'b01;
      lsPend = 0;
      abortAt = 2;
      applyStimulus();
      defaults();
      lsPend = 1; lsAddr = 32'h8000_0044; lsSize = 3'd2;
      applyStimulus();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
